multicycle_control_unit: RTL and testbench
==========================================

# multicycle_control_unit

Parametrised multi-cycle control unit for the 16-bit-class CPU: it fetches each instruction, decodes the 4-bit opcode and sequences the datapath (PC, IR, register file, ALU, data memory) through Moore-style states. It adds register-field width generalisation, variable-latency memory handshakes, logic/shift ALU ops, absolute jump, relative BEQ/BNE, HALT resume and an illegal-opcode trap. It sits between instruction/data memory and the datapath, replacing the fixed 16-bit control unit.

## Interface
- REG_ADDR_W, 4: register address width R; INSTR_W = 4+3R, DATA_ADDR_W = PC_W = 2R (derived localparams)
- Clock  in  1  rising-edge clock
- Reset_n  in  1  asynchronous, active-low reset
- IR  in  INSTR_W  current instruction register contents
- I_RDY  in  1  instruction memory data valid
- D_RDY  in  1  data memory read data valid / write accepted
- ALU_Z  in  1  ALU result zero flag
- Go  in  1  resume from HALT
- PC_CLR, PC_IC, PC_LD, PC_ADD  out  1 each  PC clear / +1 / load PC_TGT / add sign-extended PC_TGT
- PC_TGT  out  PC_W  jump target or branch offset
- IR_LD  out  1  IR load strobe
- D_ADDR  out  DATA_ADDR_W  data memory address
- D_RD, D_WR  out  1 each  data memory read / write request
- RF_S  out  1  RF write mux: 1 = memory, 0 = ALU
- RF_W_EN  out  1  RF write enable
- RF_A_ADDR, RF_B_ADDR, RF_W_ADDR  out  R each  RF addresses
- ALU_S  out  4  ALU select: 0 pass, 1 add, 2 sub, 3 and, 4 or, 5 xor, 6 shl, 7 shr
- Halted, Illegal  out  1 each  status
- state  out  5  current state code

## Operation
- Fields: OP = IR[INSTR_W-1:INSTR_W-4], F2 = IR[3R-1:2R], F1 = IR[2R-1:R], F0 = IR[R-1:0], LO = IR[2R-1:0], MID = IR[3R-1:R].
- Opcodes: 0 NOOP, 1 STORE, 2 LOAD, 3 ADD, 4 SUB, 5 HALT, 6 AND, 7 OR, 8 XOR, 9 SHL, A SHR, B JMP, C BEQ, D BNE, E/F illegal.
- States (code): INIT 0, FETCH 1, DECODE 2, LOAD_REQ 3, LOAD_WB 4, STORE 5, ALU 6, BRANCH 7, JUMP 8, HALT 9, NOOP A, TRAP B.
- Every output defaults to 0 in every state; only the listed outputs are driven. Outputs are combinational from state, IR and the handshake inputs.
- INIT: PC_CLR=1 -> FETCH.
- FETCH: IR_LD = I_RDY. If I_RDY -> DECODE, else stay.
- DECODE: PC_IC=1. Next state by OP: 0 NOOP, 1 STORE, 2 LOAD_REQ, 3/4/6-A ALU, 5 HALT, B JUMP, C/D BRANCH, E/F TRAP.
- LOAD_REQ: D_RD=1, D_ADDR=MID, RF_S=1, RF_W_ADDR=F0. If D_RDY -> LOAD_WB, else stay.
- LOAD_WB: D_ADDR=MID, RF_S=1, RF_W_ADDR=F0, RF_W_EN=1 -> FETCH.
- STORE: D_WR=1, D_ADDR=LO, RF_A_ADDR=F2. If D_RDY -> FETCH, else stay.
- ALU: RF_A_ADDR=F2, RF_B_ADDR=F1, RF_W_ADDR=F0, RF_W_EN=1, RF_S=0, ALU_S = opcode map (3→1, 4→2, 6→3, 7→4, 8→5, 9→6, A→7) -> FETCH.
- BRANCH: RF_A_ADDR=F2, RF_B_ADDR=F1, ALU_S=2, PC_TGT = sign-extended F0. PC_ADD=1 when (OP=C and ALU_Z) or (OP=D and !ALU_Z) -> FETCH. The offset is relative to the already-incremented PC.
- JUMP: PC_LD=1, PC_TGT=LO -> FETCH.
- NOOP: -> FETCH.
- HALT: Halted=1. Go -> FETCH, else stay. Go is ignored in all other states.
- TRAP: Illegal=1. Stays in TRAP until reset.

## Timing
- Reset_n low: state=INIT immediately (asynchronous), so PC_CLR=1 and all other outputs are 0, including D_WR and RF_W_EN mid-operation. The first FETCH occurs in the cycle after the first rising edge with Reset_n high.
- Zero-wait latencies (I_RDY/D_RDY high): ALU/JUMP/BRANCH/NOOP/STORE take 3 cycles; LOAD takes 4 cycles.
- Each cycle of I_RDY or D_RDY low adds exactly one cycle. Request outputs are held stable while waiting.
- PC_IC is asserted for exactly one cycle per instruction, in DECODE.
- The state register updates only on rising Clock edges (except asynchronous reset).

## Test plan
- Reset: hold Reset_n=0 mid-STORE -> D_WR drops to 0 without a clock edge and state=0. Release -> one INIT cycle with PC_CLR=1, then FETCH.
- ADD, IR=16'h3125, zero wait -> in ALU: RF_A=1, RF_B=2, RF_W=5, ALU_S=1, RF_W_EN=1. Total 3 cycles.
- LOAD, IR=16'h2A73, D_RDY low 2 cycles -> LOAD_REQ lasts 3 cycles with D_ADDR=8'hA7 and D_RD=1. Then LOAD_WB with RF_W_EN=1, RF_W_ADDR=3, RF_S=1.
- BEQ, IR=16'hC12E: ALU_Z=1 -> PC_ADD=1, PC_TGT=8'hFE. ALU_Z=0 -> PC_ADD=0. BNE is checked likewise with the opposite result.
- JMP, IR=16'hB03C -> PC_LD=1, PC_TGT=8'h3C. HALT -> Halted=1 held for 5 cycles, Go pulse -> FETCH next cycle.
- Opcode F -> TRAP with Illegal=1, held while Go toggles. Reset clears it.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit: fetch/decode/sequence for the 4+3R-bit ISA.
// Moore-style FSM with variable-latency memory handshakes and HALT/TRAP.
module multicycle_control_unit #(
  parameter int REG_ADDR_W = 4,
  localparam int R = REG_ADDR_W,
  localparam int INSTR_W = 4 + 3 * R,
  localparam int PC_W = 2 * R,
  localparam int DATA_ADDR_W = 2 * R
) (
  input  logic                   Clock,
  input  logic                   Reset_n,
  input  logic [INSTR_W-1:0]     IR,
  input  logic                   I_RDY,
  input  logic                   D_RDY,
  input  logic                   ALU_Z,
  input  logic                   Go,
  output logic                   PC_CLR,
  output logic                   PC_IC,
  output logic                   PC_LD,
  output logic                   PC_ADD,
  output logic [PC_W-1:0]        PC_TGT,
  output logic                   IR_LD,
  output logic [DATA_ADDR_W-1:0] D_ADDR,
  output logic                   D_RD,
  output logic                   D_WR,
  output logic                   RF_S,
  output logic                   RF_W_EN,
  output logic [R-1:0]           RF_A_ADDR,
  output logic [R-1:0]           RF_B_ADDR,
  output logic [R-1:0]           RF_W_ADDR,
  output logic [3:0]             ALU_S,
  output logic                   Halted,
  output logic                   Illegal,
  output logic [4:0]             state
);

  typedef enum logic [4:0] {
    S_INIT     = 5'd0,
    S_FETCH    = 5'd1,
    S_DECODE   = 5'd2,
    S_LOAD_REQ = 5'd3,
    S_LOAD_WB  = 5'd4,
    S_STORE    = 5'd5,
    S_ALU      = 5'd6,
    S_BRANCH   = 5'd7,
    S_JUMP     = 5'd8,
    S_HALT     = 5'd9,
    S_NOOP     = 5'd10,
    S_TRAP     = 5'd11
  } state_e;

  state_e state_q, state_d;

  logic [3:0]      op;
  logic [R-1:0]    f2, f1, f0;
  logic [2*R-1:0]  lo, mid;
  logic            is_alu, is_br, br_take;

  assign op  = IR[INSTR_W-1 -: 4];
  assign f2  = IR[3*R-1 -: R];
  assign f1  = IR[2*R-1 -: R];
  assign f0  = IR[R-1:0];
  assign lo  = IR[2*R-1:0];
  assign mid = IR[3*R-1:R];

  assign is_alu  = op inside {4'h3, 4'h4, [4'h6:4'hA]};
  assign is_br   = op inside {4'hC, 4'hD};
  assign br_take = (op == 4'hC) ? ALU_Z : !ALU_Z;

  // ADD/SUB sit at 3-4, logic/shift ops at 6-A; HALT at 5 splits them
  function automatic logic [3:0] alu_sel(input logic [3:0] o);
    alu_sel = (o < 4'h5) ? o - 4'h2 : o - 4'h3;
  endfunction

  assign state = state_q;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) state_q <= S_INIT;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    PC_CLR    = 1'b0;
    PC_IC     = 1'b0;
    PC_LD     = 1'b0;
    PC_ADD    = 1'b0;
    PC_TGT    = '0;
    IR_LD     = 1'b0;
    D_ADDR    = '0;
    D_RD      = 1'b0;
    D_WR      = 1'b0;
    RF_S      = 1'b0;
    RF_W_EN   = 1'b0;
    RF_A_ADDR = '0;
    RF_B_ADDR = '0;
    RF_W_ADDR = '0;
    ALU_S     = 4'd0;
    Halted    = 1'b0;
    Illegal   = 1'b0;
    unique case (state_q)
      S_INIT: begin
        PC_CLR  = 1'b1;
        state_d = S_FETCH;
      end
      S_FETCH: begin
        IR_LD = I_RDY;
        if (I_RDY) state_d = S_DECODE;
      end
      S_DECODE: begin
        PC_IC = 1'b1;
        unique case (1'b1)
          op == 4'h0: state_d = S_NOOP;
          op == 4'h1: state_d = S_STORE;
          op == 4'h2: state_d = S_LOAD_REQ;
          op == 4'h5: state_d = S_HALT;
          op == 4'hB: state_d = S_JUMP;
          is_alu:     state_d = S_ALU;
          is_br:      state_d = S_BRANCH;
          default:    state_d = S_TRAP;
        endcase
      end
      S_LOAD_REQ: begin
        D_RD      = 1'b1;
        D_ADDR    = mid;
        RF_S      = 1'b1;
        RF_W_ADDR = f0;
        if (D_RDY) state_d = S_LOAD_WB;
      end
      S_LOAD_WB: begin
        D_ADDR    = mid;
        RF_S      = 1'b1;
        RF_W_ADDR = f0;
        RF_W_EN   = 1'b1;
        state_d   = S_FETCH;
      end
      S_STORE: begin
        D_WR      = 1'b1;
        D_ADDR    = lo;
        RF_A_ADDR = f2;
        if (D_RDY) state_d = S_FETCH;
      end
      S_ALU: begin
        RF_A_ADDR = f2;
        RF_B_ADDR = f1;
        RF_W_ADDR = f0;
        RF_W_EN   = 1'b1;
        ALU_S     = alu_sel(op);
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        RF_A_ADDR = f2;
        RF_B_ADDR = f1;
        ALU_S     = 4'd2;
        PC_TGT    = {{(PC_W-R){f0[R-1]}}, f0};
        PC_ADD    = br_take;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        PC_LD   = 1'b1;
        PC_TGT  = lo;
        state_d = S_FETCH;
      end
      S_HALT: begin
        Halted = 1'b1;
        if (Go) state_d = S_FETCH;
      end
      S_NOOP:  state_d = S_FETCH;
      S_TRAP:  Illegal = 1'b1;
      default: state_d = S_INIT;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: directed scenarios plus a randomized
// instruction stream checked cycle-by-cycle against a behavioural model.
module tb_multicycle_control_unit;

  logic        Clock, Reset_n;
  logic [15:0] IR;
  logic        I_RDY, D_RDY, ALU_Z, Go;
  logic        PC_CLR, PC_IC, PC_LD, PC_ADD, IR_LD;
  logic [7:0]  PC_TGT, D_ADDR;
  logic        D_RD, D_WR, RF_S, RF_W_EN, Halted, Illegal;
  logic [3:0]  RF_A_ADDR, RF_B_ADDR, RF_W_ADDR, ALU_S;
  logic [4:0]  state;

  int checks = 0;
  int failures = 0;

  multicycle_control_unit #(.REG_ADDR_W(4)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .IR(IR),
    .I_RDY(I_RDY), .D_RDY(D_RDY), .ALU_Z(ALU_Z), .Go(Go),
    .PC_CLR(PC_CLR), .PC_IC(PC_IC), .PC_LD(PC_LD), .PC_ADD(PC_ADD),
    .PC_TGT(PC_TGT), .IR_LD(IR_LD), .D_ADDR(D_ADDR),
    .D_RD(D_RD), .D_WR(D_WR), .RF_S(RF_S), .RF_W_EN(RF_W_EN),
    .RF_A_ADDR(RF_A_ADDR), .RF_B_ADDR(RF_B_ADDR),
    .RF_W_ADDR(RF_W_ADDR), .ALU_S(ALU_S),
    .Halted(Halted), .Illegal(Illegal), .state(state)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct packed {
    logic       clr, ic, ld, add;
    logic [7:0] tgt;
    logic       irld;
    logic [7:0] daddr;
    logic       rd, wr, rfs, rfwe;
    logic [3:0] ra, rb, rw, alus;
    logic       halted, illegal;
    logic [4:0] st;
  } outs_t;

  typedef struct {
    logic [15:0] ir;
    logic        irdy, drdy, z, go;
    outs_t       e;
  } cyc_t;

  outs_t obs, e;
  cyc_t  q[$];

  assign obs = {PC_CLR, PC_IC, PC_LD, PC_ADD, PC_TGT, IR_LD, D_ADDR,
                D_RD, D_WR, RF_S, RF_W_EN, RF_A_ADDR, RF_B_ADDR,
                RF_W_ADDR, ALU_S, Halted, Illegal, state};

  function automatic outs_t so(input logic [4:0] s);
    outs_t o = '0;
    o.st = s;
    return o;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // drive an instruction through FETCH and DECODE; ends in its first exec cycle
  task automatic go_decode(input logic [15:0] ir);
    I_RDY = 1'b1;
    tick();
    IR = ir;
    I_RDY = 1'b0;
    tick();
  endtask

  task automatic push(input logic [15:0] ir, input logic irdy, drdy, z, go,
                      input outs_t ex);
    cyc_t c;
    c.ir = ir; c.irdy = irdy; c.drdy = drdy; c.z = z; c.go = go; c.e = ex;
    q.push_back(c);
  endtask

  // ALU select is the 1-based position of the opcode in the ALU-op list
  function automatic logic [3:0] alu_code(input logic [3:0] op);
    int ops[7] = '{3, 4, 6, 7, 8, 9, 10};
    for (int i = 0; i < 7; i++)
      if (int'(op) == ops[i]) return 4'(i + 1);
    return 4'd0;
  endfunction

  task automatic model(input logic [15:0] ir, prev, input int iw, dw, hw,
                       input logic z);
    outs_t x;
    logic [3:0] op, f2, f1, f0;
    logic [7:0] lo, mid;
    op = ir[15:12]; f2 = ir[11:8]; f1 = ir[7:4]; f0 = ir[3:0];
    lo = ir[7:0]; mid = ir[11:4];
    for (int i = 0; i < iw; i++) push(prev, 1'b0, rb(), rb(), rb(), so(1));
    x = so(1); x.irld = 1'b1;
    push(prev, 1'b1, rb(), rb(), rb(), x);
    x = so(2); x.ic = 1'b1;
    push(ir, rb(), rb(), rb(), rb(), x);
    if (op == 4'h2) begin
      x = so(3); x.rd = 1'b1; x.daddr = mid; x.rfs = 1'b1; x.rw = f0;
      for (int i = 0; i <= dw; i++) push(ir, rb(), i == dw, rb(), rb(), x);
      x = so(4); x.daddr = mid; x.rfs = 1'b1; x.rw = f0; x.rfwe = 1'b1;
      push(ir, rb(), rb(), rb(), rb(), x);
    end else if (op == 4'h1) begin
      x = so(5); x.wr = 1'b1; x.daddr = lo; x.ra = f2;
      for (int i = 0; i <= dw; i++) push(ir, rb(), i == dw, rb(), rb(), x);
    end else if (alu_code(op) != 0) begin
      x = so(6); x.ra = f2; x.rb = f1; x.rw = f0; x.rfwe = 1'b1;
      x.alus = alu_code(op);
      push(ir, rb(), rb(), rb(), rb(), x);
    end else if (op == 4'hC || op == 4'hD) begin
      x = so(7); x.ra = f2; x.rb = f1; x.alus = 4'd2;
      x.tgt = 8'(signed'(f0));
      x.add = (op == 4'hC) ? z : !z;
      push(ir, rb(), rb(), z, rb(), x);
    end else if (op == 4'hB) begin
      x = so(8); x.ld = 1'b1; x.tgt = lo;
      push(ir, rb(), rb(), rb(), rb(), x);
    end else if (op == 4'h5) begin
      x = so(9); x.halted = 1'b1;
      for (int i = 0; i <= hw; i++) push(ir, rb(), rb(), rb(), i == hw, x);
    end else begin
      push(ir, rb(), rb(), rb(), rb(), so(10));
    end
  endtask

  task automatic test_reset();
    Reset_n = 1'b1; IR = '0; I_RDY = 0; D_RDY = 0; ALU_Z = 0; Go = 0;
    #2 Reset_n = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    e = so(0); e.clr = 1'b1;
    if (obs !== e) begin failures++; $display("FAIL reset_hold got=%h exp=%h", obs, e); end
    checks++;
    Reset_n = 1'b1;
    #1;
    if (obs !== e) begin failures++; $display("FAIL reset_release got=%h exp=%h", obs, e); end
    checks++;
    tick();
    e = so(1);
    if (obs !== e) begin failures++; $display("FAIL first_fetch got=%h exp=%h", obs, e); end
    checks++;
  endtask

  task automatic test_add();
    I_RDY = 1'b1;
    #1;
    e = so(1); e.irld = 1'b1;
    if (obs !== e) begin failures++; $display("FAIL add_fetch got=%h exp=%h", obs, e); end
    checks++;
    tick();
    IR = 16'h3125; I_RDY = 1'b0;
    #1;
    e = so(2); e.ic = 1'b1;
    if (obs !== e) begin failures++; $display("FAIL add_decode got=%h exp=%h", obs, e); end
    checks++;
    tick();
    e = so(6); e.ra = 4'd1; e.rb = 4'd2; e.rw = 4'd5; e.alus = 4'd1; e.rfwe = 1'b1;
    if (obs !== e) begin failures++; $display("FAIL add_exec got=%h exp=%h", obs, e); end
    checks++;
    tick();
    if (state !== 5'd1) begin failures++; $display("FAIL add_latency got=%0d exp=1", state); end
    checks++;
  endtask

  task automatic test_load_wait();
    go_decode(16'h2A73);
    D_RDY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      D_RDY = (i == 2);
      #1;
      e = so(3); e.rd = 1'b1; e.daddr = 8'hA7; e.rfs = 1'b1; e.rw = 4'd3;
      if (obs !== e) begin failures++; $display("FAIL load_req%0d got=%h exp=%h", i, obs, e); end
      checks++;
      tick();
    end
    D_RDY = 1'b0;
    #1;
    e = so(4); e.daddr = 8'hA7; e.rfs = 1'b1; e.rw = 4'd3; e.rfwe = 1'b1;
    if (obs !== e) begin failures++; $display("FAIL load_wb got=%h exp=%h", obs, e); end
    checks++;
    tick();
    if (state !== 5'd1) begin failures++; $display("FAIL load_done got=%0d exp=1", state); end
    checks++;
  endtask

  task automatic test_branch();
    logic [15:0] irs[4] = '{16'hC12E, 16'hC12E, 16'hD12E, 16'hD12E};
    logic        zs[4]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic        tk[4]  = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      go_decode(irs[i]);
      ALU_Z = zs[i];
      #1;
      e = so(7); e.ra = 4'd1; e.rb = 4'd2; e.alus = 4'd2;
      e.tgt = 8'hFE; e.add = tk[i];
      if (obs !== e) begin failures++; $display("FAIL branch%0d got=%h exp=%h", i, obs, e); end
      checks++;
      tick();
      ALU_Z = 1'b0;
      if (state !== 5'd1) begin failures++; $display("FAIL branch_done%0d got=%0d exp=1", i, state); end
      checks++;
    end
  endtask

  task automatic test_jump_halt();
    go_decode(16'hB03C);
    #1;
    e = so(8); e.ld = 1'b1; e.tgt = 8'h3C;
    if (obs !== e) begin failures++; $display("FAIL jump got=%h exp=%h", obs, e); end
    checks++;
    tick();
    go_decode(16'h5000);
    Go = 1'b0;
    e = so(9); e.halted = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (obs !== e) begin failures++; $display("FAIL halt_hold%0d got=%h exp=%h", i, obs, e); end
      checks++;
      tick();
    end
    Go = 1'b1;
    #1;
    if (obs !== e) begin failures++; $display("FAIL halt_go got=%h exp=%h", obs, e); end
    checks++;
    tick();
    Go = 1'b0;
    #1;
    if (state !== 5'd1) begin failures++; $display("FAIL halt_resume got=%0d exp=1", state); end
    checks++;
  endtask

  task automatic test_reset_mid_store();
    go_decode(16'h1A5C);
    D_RDY = 1'b0;
    #1;
    e = so(5); e.wr = 1'b1; e.daddr = 8'h5C; e.ra = 4'hA;
    if (obs !== e) begin failures++; $display("FAIL store_wait got=%h exp=%h", obs, e); end
    checks++;
    #2 Reset_n = 1'b0;
    #1;
    e = so(0); e.clr = 1'b1;
    if (obs !== e) begin failures++; $display("FAIL reset_async got=%h exp=%h", obs, e); end
    checks++;
    tick();
    Reset_n = 1'b1;
    #1;
    if (obs !== e) begin failures++; $display("FAIL reset_init got=%h exp=%h", obs, e); end
    checks++;
    tick();
    if (obs !== so(1)) begin failures++; $display("FAIL reset_fetch got=%h exp=%h", obs, so(1)); end
    checks++;
  endtask

  task automatic test_random();
    logic [15:0] prev, ir;
    int          n;
    prev = IR;
    q.delete();
    for (int k = 0; k < 60; k++) begin
      ir = 16'($urandom());
      ir[15:12] = 4'($urandom_range(0, 13));
      model(ir, prev, $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 4), rb());
      prev = ir;
    end
    n = q.size();
    for (int i = 0; i < n; i++) begin
      IR = q[i].ir; I_RDY = q[i].irdy; D_RDY = q[i].drdy;
      ALU_Z = q[i].z; Go = q[i].go;
      #1;
      if (obs !== q[i].e) begin
        failures++;
        $display("FAIL rand_cyc%0d ir=%h got=%h exp=%h", i, q[i].ir, obs, q[i].e);
      end
      checks++;
      tick();
    end
    I_RDY = 1'b0; Go = 1'b0;
    #1;
    if (state !== 5'd1) begin failures++; $display("FAIL rand_end got=%0d exp=1", state); end
    checks++;
  endtask

  task automatic test_trap();
    go_decode(16'hF000);
    e = so(11); e.illegal = 1'b1;
    for (int i = 0; i < 6; i++) begin
      Go = 1'(i % 2);
      #1;
      if (obs !== e) begin failures++; $display("FAIL trap%0d got=%h exp=%h", i, obs, e); end
      checks++;
      tick();
    end
    Go = 1'b0;
    Reset_n = 1'b0;
    #1;
    e = so(0); e.clr = 1'b1;
    if (obs !== e) begin failures++; $display("FAIL trap_reset got=%h exp=%h", obs, e); end
    checks++;
    tick();
    Reset_n = 1'b1;
    tick();
    if (state !== 5'd1) begin failures++; $display("FAIL trap_recover got=%0d exp=1", state); end
    checks++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_load_wait();
    test_branch();
    test_jump_halt();
    test_reset_mid_store();
    test_random();
    test_trap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
